riscv_io_shell: RTL and testbench
=================================

Name: riscv_io_shell

Overview:
- Self-contained top-level I/O shell for the RISC-V FPGA build.
- Conditions the board clock and reset, and provides a UART host link: bytes received on Rx are buffered in a FIFO and echoed unchanged on Tx.
- Drives status LEDs.
- The SIM parameter shrinks bit timing so simulation runs in a few thousand cycles.

Parameters:
- SIM, 0: 1 selects the simulation bit period SIM_BAUD_DIV; 0 selects SYS_CLK_FREQ/BAUD_RATE (integer division).
- SYS_CLK_FREQ, 100000000: board clock in Hz.
- BAUD_RATE, 115200: UART bit rate for SIM=0.
- SIM_BAUD_DIV, 8: clocks per UART bit when SIM=1; must be an even number of at least 4.
- FIFO_DEPTH_LOG2, 4: RX-to-TX FIFO depth is 2^FIFO_DEPTH_LOG2 bytes.

Ports:
- EXCLK  input  1  single system clock; all logic is on the rising edge.
- btnC  input  1  reset, asynchronous, active-low (0 = reset).
- Rx  input  1  UART receive line, idle high; asynchronous to EXCLK.
- Tx  output  1  UART transmit line, idle high.
- led  output  2  led[0] toggles on every accepted byte; led[1] is a sticky error flag.

Behaviour:
- Reset assertion is asynchronous. Deassertion is synchronized through 2 flops; internal logic leaves reset 2 EXCLK edges after btnC rises.
- Values during reset:
  - Tx=1, led=2'b00.
  - FIFO empty; RX and TX FSMs in IDLE.
  - Rx synchronizer flops preset to 1.
- DIV is the selected bit period; HALF = DIV/2.
- Rx passes through a 2-flop synchronizer. All RX timing below uses the synchronized value.
- RX FSM, states IDLE, START, DATA, STOP:
  - IDLE -> START on synchronized Rx=0.
  - START: after HALF cycles re-sample. If still 0, go to DATA; if 1, treat as a glitch and return to IDLE with no side effect.
  - DATA: sample every DIV cycles, 8 bits, LSB first.
  - STOP: sample after DIV cycles.
    - Stop=1: push the byte into the FIFO on the next cycle and toggle led[0].
    - Stop=0: framing error; discard the byte and set led[1].
  - STOP always returns to IDLE.
- FIFO:
  - Synchronous, circular pointers that wrap modulo depth; full and empty are distinguished by an extra pointer bit.
  - A push while full drops the byte, sets led[1], and does not toggle led[0].
  - A push and pop in the same cycle are both honoured.
- TX FSM, states IDLE, START, DATA, STOP:
  - IDLE with FIFO non-empty: pop one byte. Tx goes low on the following cycle.
  - Start bit lasts DIV cycles, then 8 data bits LSB first at DIV cycles each, then stop bit (1) for DIV cycles, then back to IDLE.
  - Back-to-back bytes: the next start bit may begin the cycle after the stop bit completes.
- led[1] is cleared only by reset.
- Reset mid-frame: Tx returns to 1 immediately (asynchronous); partial RX/TX bytes and FIFO contents are lost.
- End-to-end latency: the echoed start bit begins no more than 3 cycles after the RX stop-bit sample.

Test Plan:
- Reset check: btnC=0 for 25 cycles -> Tx=1, led=00 throughout. Release btnC; with Rx idle -> Tx stays 1 for 2000 cycles.
- Single echo, SIM=1, DIV=8: send 0x55 (10 bits, 8 cycles each) -> Tx emits start, 1,0,1,0,1,0,1,0 (LSB first), stop; decoded byte 0x55; led=01.
- Burst: send 0xA3, 0x00, 0xFF back-to-back -> the same three bytes echoed in order with no loss; led[0] toggled 3 times (led=01); led[1]=0.
- Glitch and framing error:
  - 2-cycle low pulse on Rx -> no echo, led unchanged.
  - Byte 0x3C with stop bit forced 0 -> no echo, led[1]=1, led[0] unchanged.
- Overflow: hold the TX FSM busy with a forced long run and push 17 bytes with depth 16 -> the 17th byte is dropped, led[1]=1, and the first 16 are echoed in order.
- Reset mid-frame: assert btnC during the 4th data bit of an echo -> Tx=1 within the same cycle, led=00; after release, a new byte 0x81 echoes correctly.

Source files
------------

// File: rtl/riscv_io_shell.sv
// Top-level I/O shell: reset conditioning, UART receiver feeding a byte FIFO that is
// echoed back out by a UART transmitter, and two status LEDs.
module riscv_io_shell #(
    parameter int SIM             = 0,
    parameter int SYS_CLK_FREQ    = 100000000,
    parameter int BAUD_RATE       = 115200,
    parameter int SIM_BAUD_DIV    = 8,
    parameter int FIFO_DEPTH_LOG2 = 4
) (
    input  logic       EXCLK,
    input  logic       btnC,
    input  logic       Rx,
    output logic       Tx,
    output logic [1:0] led
);
    localparam int DIV   = (SIM != 0) ? SIM_BAUD_DIV : SYS_CLK_FREQ / BAUD_RATE;
    localparam int HALF  = DIV / 2;
    localparam int CW    = $clog2(DIV + 1);
    localparam int AW    = FIFO_DEPTH_LOG2;
    localparam int DEPTH = 1 << AW;
    localparam logic [CW-1:0] DIV_M1  = CW'(DIV - 1);
    localparam logic [CW-1:0] HALF_M1 = CW'(HALF - 1);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    // Reset asserts asynchronously, releases two edges after btnC rises.
    logic [1:0] rst_sync_q;
    logic       rst_n;
    always_ff @(posedge EXCLK or negedge btnC) begin
        if (!btnC) rst_sync_q <= 2'b00;
        else       rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
    assign rst_n = rst_sync_q[1];

    logic [1:0] rx_sync_q;
    logic       rx_s;
    always_ff @(posedge EXCLK or negedge rst_n) begin
        if (!rst_n) rx_sync_q <= 2'b11;
        else        rx_sync_q <= {rx_sync_q[0], Rx};
    end
    assign rx_s = rx_sync_q[1];

    // ---------------- receiver ----------------
    state_t          rx_state_q, rx_state_d;
    logic [CW-1:0]   rx_cnt_q, rx_cnt_d;
    logic [2:0]      rx_bit_q, rx_bit_d;
    logic [7:0]      rx_shift_q, rx_shift_d;
    logic            push_q, push_d;
    logic            frame_err;

    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        push_d     = 1'b0;
        frame_err  = 1'b0;
        unique case (rx_state_q)
            S_IDLE: if (!rx_s) begin
                rx_state_d = S_START;
                rx_cnt_d   = '0;
            end
            S_START: if (rx_cnt_q == HALF_M1) begin
                rx_cnt_d   = '0;
                rx_bit_d   = '0;
                rx_state_d = rx_s ? S_IDLE : S_DATA;
            end else rx_cnt_d = rx_cnt_q + 1'b1;
            S_DATA: if (rx_cnt_q == DIV_M1) begin
                rx_cnt_d   = '0;
                rx_shift_d = {rx_s, rx_shift_q[7:1]};
                if (rx_bit_q == 3'd7) rx_state_d = S_STOP;
                else                  rx_bit_d   = rx_bit_q + 1'b1;
            end else rx_cnt_d = rx_cnt_q + 1'b1;
            S_STOP: if (rx_cnt_q == DIV_M1) begin
                rx_state_d = S_IDLE;
                push_d     = rx_s;
                frame_err  = !rx_s;
            end else rx_cnt_d = rx_cnt_q + 1'b1;
            default: rx_state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge EXCLK or negedge rst_n) begin
        if (!rst_n) begin
            rx_state_q <= S_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
            push_q     <= 1'b0;
        end else begin
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            push_q     <= push_d;
        end
    end

    // ---------------- FIFO ----------------
    logic [7:0]  mem [DEPTH];
    logic [AW:0] wr_ptr_q, rd_ptr_q;
    logic        empty, full, do_push, ovf, tx_go;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_push = push_q && !full;
    assign ovf     = push_q && full;

    always_ff @(posedge EXCLK) begin
        if (do_push) mem[wr_ptr_q[AW-1:0]] <= rx_shift_q;
    end

    // ---------------- transmitter ----------------
    state_t        tx_state_q, tx_state_d;
    logic [CW-1:0] tx_cnt_q, tx_cnt_d;
    logic [2:0]    tx_bit_q, tx_bit_d;
    logic [7:0]    tx_shift_q, tx_shift_d;
    logic          tx_q, tx_d;

    assign tx_go = (tx_state_q == S_IDLE) && !empty;

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        tx_d       = tx_q;
        unique case (tx_state_q)
            S_IDLE: if (tx_go) begin
                tx_state_d = S_START;
                tx_cnt_d   = '0;
                tx_shift_d = mem[rd_ptr_q[AW-1:0]];
                tx_d       = 1'b0;
            end
            S_START: if (tx_cnt_q == DIV_M1) begin
                tx_cnt_d   = '0;
                tx_bit_d   = '0;
                tx_d       = tx_shift_q[0];
                tx_shift_d = {1'b0, tx_shift_q[7:1]};
                tx_state_d = S_DATA;
            end else tx_cnt_d = tx_cnt_q + 1'b1;
            S_DATA: if (tx_cnt_q == DIV_M1) begin
                tx_cnt_d = '0;
                if (tx_bit_q == 3'd7) begin
                    tx_d       = 1'b1;
                    tx_state_d = S_STOP;
                end else begin
                    tx_d       = tx_shift_q[0];
                    tx_shift_d = {1'b0, tx_shift_q[7:1]};
                    tx_bit_d   = tx_bit_q + 1'b1;
                end
            end else tx_cnt_d = tx_cnt_q + 1'b1;
            S_STOP: if (tx_cnt_q == DIV_M1) tx_state_d = S_IDLE;
                    else                    tx_cnt_d   = tx_cnt_q + 1'b1;
            default: tx_state_d = S_IDLE;
        endcase
    end

    logic led0_q, led1_q;
    always_ff @(posedge EXCLK or negedge rst_n) begin
        if (!rst_n) begin
            tx_state_q <= S_IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            tx_q       <= 1'b1;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            led0_q     <= 1'b0;
            led1_q     <= 1'b0;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            tx_q       <= tx_d;
            wr_ptr_q   <= wr_ptr_q + (AW+1)'(do_push);
            rd_ptr_q   <= rd_ptr_q + (AW+1)'(tx_go);
            led0_q     <= led0_q ^ do_push;
            led1_q     <= led1_q | frame_err | ovf;
        end
    end

    assign Tx  = tx_q;
    assign led = {led1_q, led0_q};
endmodule

// File: tb/tb_riscv_io_shell.sv
// Bench for riscv_io_shell: drives UART frames on Rx, decodes Tx, and scores echoed bytes.
module tb_riscv_io_shell;
    localparam int DIV  = 8;
    localparam int HALF = DIV / 2;

    logic       EXCLK = 1'b0;
    logic       btnC  = 1'b1;
    logic       Rx    = 1'b1;
    logic       Tx;
    logic [1:0] led;

    riscv_io_shell #(.SIM(1), .SIM_BAUD_DIV(DIV), .FIFO_DEPTH_LOG2(4)) dut (
        .EXCLK(EXCLK), .btnC(btnC), .Rx(Rx), .Tx(Tx), .led(led)
    );

    always #5 EXCLK = ~EXCLK;

    int         checks = 0;
    int         fails  = 0;
    logic [7:0] exp_q[$];
    int         mon_n    = 0;
    bit         mon_busy = 1'b0;
    int         rx_cnt   = 0;
    logic [7:0] mon_byte = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Tx decoder: samples each bit centre on the falling clock edge.
    always @(negedge EXCLK) begin
        if (!btnC) begin
            mon_busy = 1'b0;
            mon_n    = 0;
        end else if (!mon_busy) begin
            if (Tx === 1'b0) begin
                mon_busy = 1'b1;
                mon_n    = 0;
            end
        end else begin
            mon_n++;
            if (mon_n == HALF) chk("tx_start_bit", Tx, 0);
            else if (mon_n > HALF && mon_n < HALF + 9*DIV && (mon_n - HALF) % DIV == 0)
                mon_byte[(mon_n - HALF)/DIV - 1] = Tx;
            else if (mon_n == HALF + 9*DIV) begin
                chk("tx_stop_bit", Tx, 1);
                rx_cnt++;
                chk("sb_nonempty", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) chk("echo_byte", mon_byte, exp_q.pop_front());
                mon_busy = 1'b0;
            end
        end
    end

    task automatic send_byte(input logic [7:0] d, input logic stopb, input bit expect_echo);
        if (expect_echo) exp_q.push_back(d);
        @(negedge EXCLK); Rx = 1'b0;
        for (int i = 0; i < 8; i++) begin
            repeat (DIV) @(negedge EXCLK);
            Rx = d[i];
        end
        repeat (DIV) @(negedge EXCLK); Rx = stopb;
        repeat (DIV) @(negedge EXCLK); Rx = 1'b1;
    endtask

    task automatic do_reset();
        @(negedge EXCLK); btnC = 1'b0;
        repeat (5) @(negedge EXCLK);
        exp_q.delete();
        btnC = 1'b1;
        repeat (4) @(negedge EXCLK);
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || mon_busy) && n < budget) begin
            @(negedge EXCLK);
            n++;
        end
        chk("drain_left", exp_q.size(), 0);
    endtask

    initial begin
        int tx_low;
        int cnt0;
        int n;
        #1 btnC = 1'b0;

        for (int i = 0; i < 25; i++) begin
            @(negedge EXCLK);
            chk("rst_tx", Tx, 1);
            chk("rst_led", led, 0);
        end
        btnC = 1'b1;
        tx_low = 0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge EXCLK);
            if (Tx !== 1'b1) tx_low++;
        end
        chk("idle_tx_low_cycles", tx_low, 0);
        chk("idle_led", led, 0);

        send_byte(8'h55, 1'b1, 1'b1);
        wait_drain(400);
        chk("single_led", led, 2'b01);

        do_reset();
        send_byte(8'hA3, 1'b1, 1'b1);
        send_byte(8'h00, 1'b1, 1'b1);
        send_byte(8'hFF, 1'b1, 1'b1);
        wait_drain(1000);
        chk("burst_led", led, 2'b01);

        do_reset();
        cnt0 = rx_cnt;
        @(negedge EXCLK); Rx = 1'b0;
        repeat (2) @(negedge EXCLK); Rx = 1'b1;
        repeat (200) @(negedge EXCLK);
        chk("glitch_led", led, 2'b00);
        chk("glitch_no_echo", rx_cnt, cnt0);
        send_byte(8'h3C, 1'b0, 1'b0);
        repeat (200) @(negedge EXCLK);
        chk("frame_err_led", led, 2'b10);
        chk("frame_err_no_echo", rx_cnt, cnt0);

        do_reset();
        force dut.tx_go = 1'b0;
        for (int i = 0; i < 17; i++) send_byte(8'(i*13 + 7), 1'b1, i < 16);
        repeat (50) @(negedge EXCLK);
        chk("ovf_led", led, 2'b10);
        release dut.tx_go;
        wait_drain(3000);
        chk("ovf_led_after", led, 2'b10);

        do_reset();
        send_byte(8'h5A, 1'b1, 1'b1);
        n = 0;
        while (!(mon_busy && mon_n == HALF + 4*DIV) && n < 400) begin
            @(negedge EXCLK); #1;
            n++;
        end
        chk("midrst_reached_bit3", n < 400, 1);
        btnC = 1'b0;
        #1;
        chk("midrst_tx", Tx, 1);
        chk("midrst_led", led, 2'b00);
        exp_q.delete();
        repeat (5) @(negedge EXCLK);
        chk("midrst_tx_hold", Tx, 1);
        btnC = 1'b1;
        repeat (4) @(negedge EXCLK);
        send_byte(8'h81, 1'b1, 1'b1);
        wait_drain(400);
        chk("post_rst_led", led, 2'b01);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

    initial begin
        #2000000;
        fails++;
        $display("FAIL watchdog got=timeout exp=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
